// File: rtl/mem_test_pkg.sv
// ----------------------------------------------------------------------------
// mem_test_pkg
// Shared definitions for the memory traffic generator:
//   - ERR_CNT_W : width of the saturating mismatch counter
//   - state_e   : top-level FSM state encoding
// ----------------------------------------------------------------------------
package mem_test_pkg;

    localparam int ERR_CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage : mem_test_pkg

// File: rtl/mem_rd_checker.sv
// ----------------------------------------------------------------------------
// mem_rd_checker
// Tracks issued reads through a RD_LATENCY-deep pipeline of
// {valid, address, expected}. When the last stage is valid, the returning
// memory data is compared with the expected value. Mismatches bump a
// saturating counter, and the first failing address is latched.
//
// Ports
//   i_clk, i_rst_n    : clock, async active-low reset
//   i_clear           : clear error counter / first-error address (new pass)
//   i_flush           : invalidate all pipeline stages (abort)
//   i_push            : a read is issued this cycle
//   i_addr, i_exp     : address and expected data of the issued read
//   i_rd_data         : memory read data, aligned with the last stage
//   o_err_cnt         : saturating mismatch count
//   o_first_err_addr  : address of the first mismatch of the pass
// ----------------------------------------------------------------------------
module mem_rd_checker
    import mem_test_pkg::*;
#(
    parameter int RD_LATENCY = 1,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clear,
    input  logic                  i_flush,
    input  logic                  i_push,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_exp,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic [ERR_CNT_W-1:0]  o_err_cnt,
    output logic [ADDR_WIDTH-1:0] o_first_err_addr
);

    localparam int LAST = RD_LATENCY - 1;

    logic [RD_LATENCY-1:0] vld_q, vld_d;
    logic [ADDR_WIDTH-1:0] addr_q [RD_LATENCY];
    logic [ADDR_WIDTH-1:0] addr_d [RD_LATENCY];
    logic [DATA_WIDTH-1:0] exp_q  [RD_LATENCY];
    logic [DATA_WIDTH-1:0] exp_d  [RD_LATENCY];
    logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [ADDR_WIDTH-1:0] first_q, first_d;
    logic                  mismatch_s;

    // Pipeline shift, compare and error bookkeeping.
    always_comb begin
        vld_d     = vld_q;
        addr_d    = addr_q;
        exp_d     = exp_q;
        err_cnt_d = err_cnt_q;
        first_d   = first_q;

        if (i_flush) begin
            vld_d = '0;
        end else begin
            vld_d[0]  = i_push;
            addr_d[0] = i_addr;
            exp_d[0]  = i_exp;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_d[i]  = vld_q[i-1];
                addr_d[i] = addr_q[i-1];
                exp_d[i]  = exp_q[i-1];
            end
        end

        // A flushed stage no longer belongs to a live pass, so it is not judged.
        mismatch_s = vld_q[LAST] && !i_flush && (i_rd_data != exp_q[LAST]);

        if (i_clear) begin
            err_cnt_d = '0;
            first_d   = '0;
        end else if (mismatch_s) begin
            if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
                err_cnt_d = err_cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
            end else begin
                err_cnt_d = err_cnt_q;
            end
            if (err_cnt_q == {ERR_CNT_W{1'b0}}) begin
                first_d = addr_q[LAST];
            end else begin
                first_d = first_q;
            end
        end else begin
            err_cnt_d = err_cnt_q;
            first_d   = first_q;
        end
    end

    // Pipeline and error registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_q     <= '0;
            err_cnt_q <= '0;
            first_q   <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                addr_q[i] <= '0;
                exp_q[i]  <= '0;
            end
        end else begin
            vld_q     <= vld_d;
            addr_q    <= addr_d;
            exp_q     <= exp_d;
            err_cnt_q <= err_cnt_d;
            first_q   <= first_d;
        end
    end

    assign o_err_cnt        = err_cnt_q;
    assign o_first_err_addr = first_q;

endmodule : mem_rd_checker

// File: rtl/mem_traffic_gen.sv
// ----------------------------------------------------------------------------
// mem_traffic_gen
// Memory test pass generator: on i_start it writes pattern(a) = a ^ seed to
// every address, reads every address back, waits RD_LATENCY cycles for the
// last data to return, then pulses o_done. Read data is checked in
// mem_rd_checker.
//
// Ports
//   i_clk, i_rst_n          : clock, async active-low reset
//   i_start, i_abort        : start a pass (IDLE only) / abort a running pass
//   i_seed                  : pattern seed, captured on accepted start
//   o_wr_en, o_rd_en        : memory strobes (never both high)
//   o_address, o_wr_data    : memory address / write data
//   i_rd_data               : memory read data (RD_LATENCY after o_rd_en)
//   o_busy, o_done          : not-idle flag / one-cycle completion pulse
//   o_err_cnt               : saturating mismatch count of the last pass
//   o_first_err_addr        : first mismatching address of the last pass
// ----------------------------------------------------------------------------
module mem_traffic_gen
    import mem_test_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [DATA_WIDTH-1:0] i_seed,
    output logic                  o_wr_en,
    output logic                  o_rd_en,
    output logic [ADDR_WIDTH-1:0] o_address,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [ERR_CNT_W-1:0]  o_err_cnt,
    output logic [ADDR_WIDTH-1:0] o_first_err_addr
);

    localparam int                    DEPTH      = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [1:0]            DRAIN_LAST = 2'(RD_LATENCY - 1);

    // Address zero-extended or truncated to the data width, XOR seed.
    function automatic logic [DATA_WIDTH-1:0] pattern(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [DATA_WIDTH-1:0] seed
    );
        return DATA_WIDTH'(addr) ^ seed;
    endfunction

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]            drain_q, drain_d;
    logic [DATA_WIDTH-1:0] seed_q, seed_d;
    logic                  wr_en_q, wr_en_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  start_acc_s;
    logic                  flush_s;

    // Next-state logic; outputs are derived from the next state so that the
    // registered strobes line up with the state they belong to.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        drain_d     = drain_q;
        seed_d      = seed_q;
        start_acc_s = 1'b0;
        flush_s     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start && !i_abort) begin
                    state_d     = ST_WRITE;
                    cnt_d       = '0;
                    seed_d      = i_seed;
                    start_acc_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (i_abort) begin
                    state_d = ST_IDLE;
                    flush_s = 1'b1;
                end else if (cnt_q == LAST_ADDR) begin
                    state_d = ST_READ;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                end
            end
            ST_READ: begin
                if (i_abort) begin
                    state_d = ST_IDLE;
                    flush_s = 1'b1;
                end else if (cnt_q == LAST_ADDR) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                    drain_d = 2'd0;
                end else begin
                    cnt_d = cnt_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                end
            end
            ST_DRAIN: begin
                if (i_abort) begin
                    state_d = ST_IDLE;
                    flush_s = 1'b1;
                end else if (drain_q == DRAIN_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                flush_s = 1'b1;
            end
        endcase

        wr_en_d = (state_d == ST_WRITE);
        rd_en_d = (state_d == ST_READ);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);

        if (wr_en_d || rd_en_d) begin
            addr_d = cnt_d;
        end else begin
            addr_d = '0;
        end

        if (wr_en_d) begin
            wr_data_d = pattern(cnt_d, seed_d);
        end else begin
            wr_data_d = '0;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            drain_q   <= 2'd0;
            seed_q    <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            drain_q   <= drain_d;
            seed_q    <= seed_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // A read is pushed in the cycle its strobe is on the bus, i.e. the same
    // edge at which the memory samples it.
    mem_rd_checker #(
        .RD_LATENCY (RD_LATENCY),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_rd_checker (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_clear          (start_acc_s),
        .i_flush          (flush_s),
        .i_push           (rd_en_q),
        .i_addr           (addr_q),
        .i_exp            (pattern(addr_q, seed_q)),
        .i_rd_data        (i_rd_data),
        .o_err_cnt        (o_err_cnt),
        .o_first_err_addr (o_first_err_addr)
    );

    assign o_wr_en   = wr_en_q;
    assign o_rd_en   = rd_en_q;
    assign o_address = addr_q;
    assign o_wr_data = wr_data_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;

endmodule : mem_traffic_gen

// File: tb/tb_mem_traffic_gen.sv
// ----------------------------------------------------------------------------
// tb_mem_traffic_gen
// Bench for mem_traffic_gen (ADDR_WIDTH=4, DATA_WIDTH=8, RD_LATENCY=1)
// attached to a behavioural single-port memory with per-address read
// corruption. Expected results come from the pass rules: writes of a^seed to
// 0..15, reads of 0..15, o_done 34 cycles after the start cycle, error count
// = number of corrupted addresses, first error = lowest corrupted address.
// ----------------------------------------------------------------------------
module tb_mem_traffic_gen;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int RL = 1;
    localparam int DEPTH = 16;
    localparam int PASS_LEN = 2 * DEPTH + RL + 1;

    logic          clk;
    logic          rst_n;
    logic          i_start;
    logic          i_abort;
    logic [DW-1:0] i_seed;
    logic          o_wr_en;
    logic          o_rd_en;
    logic [AW-1:0] o_address;
    logic [DW-1:0] o_wr_data;
    logic [DW-1:0] i_rd_data;
    logic          o_busy;
    logic          o_done;
    logic [15:0]   o_err_cnt;
    logic [AW-1:0] o_first_err_addr;

    mem_traffic_gen #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .RD_LATENCY (RL)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_start          (i_start),
        .i_abort          (i_abort),
        .i_seed           (i_seed),
        .o_wr_en          (o_wr_en),
        .o_rd_en          (o_rd_en),
        .o_address        (o_address),
        .o_wr_data        (o_wr_data),
        .i_rd_data        (i_rd_data),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_err_cnt        (o_err_cnt),
        .o_first_err_addr (o_first_err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural memory with optional read corruption per address.
    logic [DW-1:0] mem  [DEPTH];
    logic [DW-1:0] corr [DEPTH];
    always @(posedge clk) begin
        if (o_wr_en) mem[o_address] <= o_wr_data;
        if (o_rd_en) i_rd_data <= mem[o_address] ^ corr[o_address];
    end

    // Bus monitor.
    int            overlap_cnt = 0;
    int            done_cnt;
    int            done_cyc;
    int            first_wr_cyc;
    logic [AW-1:0] wr_addr_q[$];
    logic [DW-1:0] wr_data_q[$];
    logic [AW-1:0] rd_addr_q[$];
    always @(negedge clk) begin
        if (o_wr_en && o_rd_en) overlap_cnt = overlap_cnt + 1;
        if (o_wr_en) begin
            wr_addr_q.push_back(o_address);
            wr_data_q.push_back(o_wr_data);
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
        end
        if (o_rd_en) rd_addr_q.push_back(o_address);
        if (o_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic clear_mon();
        done_cnt     = 0;
        done_cyc     = -1;
        first_wr_cyc = -1;
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_addr_q.delete();
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    // Start a pass in the current cycle; returns the start cycle number.
    task automatic kick(input logic [DW-1:0] seed, output int s);
        clear_mon();
        i_seed  = seed;
        i_start = 1'b1;
        s       = cyc;
    endtask

    // Full pass with checking against the pass rules.
    task automatic run_pass(input logic [DW-1:0] seed, input bit extra_starts, input string tag);
        int s;
        int exp_errs;
        int exp_first;
        kick(seed, s);
        for (int i = 0; i < 3 * PASS_LEN; i++) begin
            next_cycle();
            i_start = extra_starts && (cyc == s + 5 || cyc == s + 10);
            i_seed  = ~seed;
            if (done_cnt > 0 && cyc > done_cyc + 1) break;
        end
        i_start = 1'b0;

        exp_errs  = 0;
        exp_first = 0;
        for (int a = DEPTH - 1; a >= 0; a--) begin
            if (corr[a] != 8'h00) begin
                exp_errs++;
                exp_first = a;
            end
        end

        check_eq({tag, ".done_cnt"}, done_cnt, 1);
        check_eq({tag, ".done_cyc"}, done_cyc, s + PASS_LEN);
        check_eq({tag, ".first_wr_cyc"}, first_wr_cyc, s + 1);
        check_eq({tag, ".n_wr"}, wr_addr_q.size(), DEPTH);
        check_eq({tag, ".n_rd"}, rd_addr_q.size(), DEPTH);
        for (int a = 0; a < DEPTH && a < wr_addr_q.size(); a++) begin
            check_eq({tag, ".wr_addr"}, wr_addr_q[a], a);
            check_eq({tag, ".wr_data"}, wr_data_q[a], (a ^ seed) & 8'hFF);
        end
        for (int a = 0; a < DEPTH && a < rd_addr_q.size(); a++) begin
            check_eq({tag, ".rd_addr"}, rd_addr_q[a], a);
        end
        check_eq({tag, ".err_cnt"}, o_err_cnt, exp_errs);
        check_eq({tag, ".first_err"}, o_first_err_addr, exp_first);
        check_eq({tag, ".busy_after"}, o_busy, 0);
    endtask

    task automatic clear_corr();
        for (int a = 0; a < DEPTH; a++) corr[a] = 8'h00;
    endtask

    initial begin
        int s;
        rst_n   = 1'b0;
        i_start = 1'b0;
        i_abort = 1'b0;
        i_seed  = 8'h00;
        for (int a = 0; a < DEPTH; a++) mem[a] = 8'h00;
        clear_corr();
        clear_mon();
        repeat (3) next_cycle();
        check_eq("rst.busy", o_busy, 0);
        check_eq("rst.strobes", {o_wr_en, o_rd_en}, 0);
        check_eq("rst.err_cnt", o_err_cnt, 0);
        rst_n = 1'b1;
        repeat (2) next_cycle();
        check_eq("idle.done", o_done, 0);
        check_eq("idle.addr", o_address, 0);

        // Clean pass, seed 0x5A.
        run_pass(8'h5A, 1'b0, "clean5a");

        // Single corrupted read at 0x7.
        corr[7] = 8'h01;
        run_pass(8'h5A, 1'b0, "corr7");

        // Two corrupted reads, 0x3 and 0xC.
        clear_corr();
        corr[3]  = 8'h01;
        corr[12] = 8'h01;
        run_pass(8'h5A, 1'b0, "corr3c");

        // Start pulses during a pass are ignored.
        clear_corr();
        run_pass(8'h5A, 1'b1, "ignstart");

        // Abort in READ at address 3.
        kick(8'h5A, s);
        for (int i = 0; i < PASS_LEN && cyc < s + 20; i++) begin
            next_cycle();
            i_start = 1'b0;
        end
        i_abort = 1'b1;
        next_cycle();
        i_abort = 1'b0;
        check_eq("abort.cyc", cyc, s + 21);
        check_eq("abort.busy", o_busy, 0);
        check_eq("abort.strobes", {o_wr_en, o_rd_en}, 0);
        repeat (40) next_cycle();
        check_eq("abort.no_done", done_cnt, 0);
        check_eq("abort.n_rd", rd_addr_q.size(), 4);
        run_pass(8'hC3, 1'b0, "after_abort");

        // Reset in the middle of WRITE.
        kick(8'h5A, s);
        for (int i = 0; i < PASS_LEN && cyc < s + 12; i++) begin
            next_cycle();
            i_start = 1'b0;
        end
        check_eq("prerst.wr_en", o_wr_en, 1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid.wr_en", o_wr_en, 0);
        check_eq("rst_mid.addr", o_address, 0);
        check_eq("rst_mid.wr_data", o_wr_data, 0);
        check_eq("rst_mid.busy", o_busy, 0);
        repeat (2) next_cycle();
        rst_n = 1'b1;
        repeat (40) next_cycle();
        check_eq("rst_mid.no_done", done_cnt, 0);
        check_eq("rst_mid.busy_after", o_busy, 0);
        run_pass(8'h21, 1'b0, "after_rst");

        // Random seeds and random read corruption.
        for (int p = 0; p < 6; p++) begin
            for (int a = 0; a < DEPTH; a++) begin
                corr[a] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            end
            repeat ($urandom_range(0, 4)) next_cycle();
            run_pass(8'($urandom_range(0, 255)), p[0], "rand");
        end

        check_eq("no_overlap", overlap_cnt, 0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule : tb_mem_traffic_gen
